risk_alarm_fsm: RTL and testbench



---
 rtl/risk_alarm_if.sv | 20 ++
 rtl/risk_alarm_fsm.sv | 127 ++++++++++++
 tb/tb_risk_alarm_fsm.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/risk_alarm_if.sv
// Sample/alert bundle between the fuzzy risk core (master) and the alarm FSM (slave).
interface risk_alarm_if;
    logic [7:0] risk_in;
    logic       risk_valid;
    logic       ack;
    logic [1:0] level;
    logic       level_chg;
    logic       alarm_latched;
    logic [7:0] peak;

    modport master (
        output risk_in, risk_valid, ack,
        input  level, level_chg, alarm_latched, peak
    );

    modport slave (
        input  risk_in, risk_valid, ack,
        output level, level_chg, alarm_latched, peak
    );
endinterface

// File: rtl/risk_alarm_fsm.sv
// Debounced three-level risk alert with hysteresis, sticky alarm flag and peak-risk register.
// Every level step needs PERSIST consecutive qualifying valid samples.
module risk_alarm_fsm #(
    parameter int unsigned LOW_TH  = 40,
    parameter int unsigned HIGH_TH = 70,
    parameter int unsigned HYST    = 5,
    parameter int unsigned PERSIST = 4
) (
    input  logic           clk,
    input  logic           rst,
    risk_alarm_if.slave    bus
);
    localparam int unsigned CW = $clog2(PERSIST + 1);

    localparam logic [7:0]    MAX_R    = 8'd100;
    localparam logic [7:0]    LOW_UP   = 8'(LOW_TH);
    localparam logic [7:0]    HIGH_UP  = 8'(HIGH_TH);
    localparam logic [7:0]    WATCH_DN = 8'(LOW_TH - HYST);
    localparam logic [7:0]    ALERT_DN = 8'(HIGH_TH - HYST);
    localparam logic [CW-1:0] CNT_MAX  = CW'(PERSIST);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        SAFE  = 2'b00,
        WATCH = 2'b01,
        ALERT = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dir_up_q, dir_up_d;
    logic          chg_q, chg_d;
    logic          alarm_q, alarm_d;
    logic [7:0]    peak_q, peak_d;

    logic [7:0]    r;
    logic          up;
    logic          dn;
    logic          ack_ok;

    always_comb begin
        r        = (bus.risk_in > MAX_R) ? MAX_R : bus.risk_in;
        up       = 1'b0;
        dn       = 1'b0;
        state_d  = state_q;
        cnt_d    = cnt_q;
        dir_up_d = dir_up_q;
        alarm_d  = alarm_q;
        peak_d   = peak_q;
        ack_ok   = bus.ack && (state_q != ALERT);

        case (state_q)
            SAFE:    up = (r >= LOW_UP);
            WATCH: begin
                up = (r >= HIGH_UP);
                dn = (r <  WATCH_DN);
            end
            ALERT:   dn = (r <  ALERT_DN);
            default: begin
                up = 1'b0;
                dn = 1'b0;
            end
        endcase

        // dir_up_q names the condition being counted; a sample satisfying the
        // other condition starts a fresh streak of one.
        if (bus.risk_valid) begin
            if (up) begin
                cnt_d    = dir_up_q ? (cnt_q + CNT_ONE) : CNT_ONE;
                dir_up_d = 1'b1;
            end else if (dn) begin
                cnt_d    = dir_up_q ? CNT_ONE : (cnt_q + CNT_ONE);
                dir_up_d = 1'b0;
            end else begin
                cnt_d    = '0;
            end

            if (cnt_d == CNT_MAX) begin
                cnt_d = '0;
                case (state_q)
                    SAFE:    state_d = WATCH;
                    WATCH:   state_d = up ? ALERT : SAFE;
                    ALERT:   state_d = WATCH;
                    default: state_d = SAFE;
                endcase
            end
        end

        chg_d = (state_d != state_q);

        if (ack_ok) begin
            alarm_d = 1'b0;
        end
        if ((state_d == ALERT) && (state_q != ALERT)) begin
            alarm_d = 1'b1;
        end

        if (ack_ok) begin
            peak_d = bus.risk_valid ? r : 8'd0;
        end else if (bus.risk_valid && (r > peak_q)) begin
            peak_d = r;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SAFE;
            cnt_q    <= '0;
            dir_up_q <= 1'b0;
            chg_q    <= 1'b0;
            alarm_q  <= 1'b0;
            peak_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dir_up_q <= dir_up_d;
            chg_q    <= chg_d;
            alarm_q  <= alarm_d;
            peak_q   <= peak_d;
        end
    end

    assign bus.level         = state_q;
    assign bus.level_chg     = chg_q;
    assign bus.alarm_latched = alarm_q;
    assign bus.peak          = peak_q;
endmodule

// File: tb/tb_risk_alarm_fsm.sv
// Table vectors, hand-written corner sequences and randomized traffic against a
// sample-history reference model for risk_alarm_fsm (default parameters).
module tb_risk_alarm_fsm;
    localparam int P = 4;

    logic clk;
    logic rst;
    risk_alarm_if bus();

    risk_alarm_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [7:0] risk;
        logic       ack;
        int         lv;
        int         chg;
        int         al;
        int         pk;
    } vec_t;

    vec_t tbl[$];

    // Reference model: level as an integer 0..2, plus the clamped samples seen
    // since the level last changed. A step happens when the newest P samples
    // all satisfy the same up/down rule of the current level.
    int m_level, m_chg, m_alarm, m_peak;
    int hist[$];

    function automatic bit is_up(int lv, int r);
        if (lv == 0) return r >= 40;
        if (lv == 1) return r >= 70;
        return 1'b0;
    endfunction

    function automatic bit is_dn(int lv, int r);
        if (lv == 1) return r < 35;
        if (lv == 2) return r < 65;
        return 1'b0;
    endfunction

    task automatic model_step(input bit r_, input bit v_, input int k_, input bit a_);
        int  r, old_lv, new_lv;
        bit  all_up, all_dn, accepted;
        if (r_) begin
            m_level = 0; m_chg = 0; m_alarm = 0; m_peak = 0;
            hist.delete();
            return;
        end
        r      = (k_ > 100) ? 100 : k_;
        old_lv = m_level;
        new_lv = old_lv;
        if (v_) begin
            hist.push_back(r);
            while (hist.size() > P) void'(hist.pop_front());
            if (hist.size() == P) begin
                all_up = 1'b1;
                all_dn = 1'b1;
                foreach (hist[i]) begin
                    if (!is_up(old_lv, hist[i])) all_up = 1'b0;
                    if (!is_dn(old_lv, hist[i])) all_dn = 1'b0;
                end
                if (all_up) new_lv = old_lv + 1;
                else if (all_dn) new_lv = old_lv - 1;
            end
            if (new_lv != old_lv) hist.delete();
        end
        accepted = a_ && (old_lv != 2);
        if (new_lv == 2 && old_lv != 2) m_alarm = 1;
        else if (accepted) m_alarm = 0;
        if (accepted) m_peak = v_ ? r : 0;
        else if (v_ && r > m_peak) m_peak = r;
        m_chg   = (new_lv != old_lv) ? 1 : 0;
        m_level = new_lv;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int lv, input int chg, input int al, input int pk);
        chk({tag, ".level"}, int'(bus.level), lv);
        chk({tag, ".level_chg"}, int'(bus.level_chg), chg);
        chk({tag, ".alarm"}, int'(bus.alarm_latched), al);
        chk({tag, ".peak"}, int'(bus.peak), pk);
    endtask

    task automatic step(input bit r_, input bit v_, input logic [7:0] k_, input bit a_);
        rst            = r_;
        bus.risk_valid = v_;
        bus.risk_in    = k_;
        bus.ack        = a_;
        model_step(r_, v_, int'(k_), a_);
        @(posedge clk);
        #1;
    endtask

    task automatic samples(input int n, input logic [7:0] k_);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, k_, 1'b0);
    endtask

    function automatic void add(input bit r_, input bit v_, input int k_, input bit a_,
                                input int lv, input int chg, input int al, input int pk);
        vec_t v;
        v.rst = r_; v.valid = v_; v.risk = 8'(k_); v.ack = a_;
        v.lv = lv; v.chg = chg; v.al = al; v.pk = pk;
        tbl.push_back(v);
    endfunction

    function automatic void add_n(input int n, input int k_,
                                  input int lv, input int al, input int pk);
        for (int i = 0; i < n; i++) add(1'b0, 1'b1, k_, 1'b0, lv, 0, al, pk);
    endfunction

    initial begin
        rst = 1'b1;
        bus.risk_in = 8'd0;
        bus.risk_valid = 1'b0;
        bus.ack = 1'b0;

        // persistence, clamp/escalation, hysteresis, ack outside ALERT
        add(1, 0, 0, 0, 0, 0, 0, 0);
        add_n(3, 50, 0, 0, 50);
        add(0, 1, 30, 0, 0, 0, 0, 50);
        add_n(3, 50, 0, 0, 50);
        add(0, 1, 50, 0, 1, 1, 0, 50);
        add(0, 0, 0, 0, 1, 0, 0, 50);
        add_n(3, 200, 1, 0, 100);
        add(0, 1, 200, 0, 2, 1, 1, 100);
        add(0, 0, 0, 0, 2, 0, 1, 100);
        add_n(4, 67, 2, 1, 100);
        add_n(3, 64, 2, 1, 100);
        add(0, 1, 64, 0, 1, 1, 1, 100);
        add(0, 0, 0, 0, 1, 0, 1, 100);
        add_n(4, 35, 1, 1, 100);
        add_n(3, 34, 1, 1, 100);
        add(0, 1, 34, 0, 0, 1, 1, 100);
        add(0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 255, 1, 0, 0, 0, 100);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].valid, tbl[i].risk, tbl[i].ack);
            $display("vec %0d rst=%0b v=%0b risk=%0d ack=%0b -> level=%0d chg=%0b alarm=%0b peak=%0d",
                     i, tbl[i].rst, tbl[i].valid, tbl[i].risk, tbl[i].ack,
                     bus.level, bus.level_chg, bus.alarm_latched, bus.peak);
            chk_all($sformatf("vec%0d", i), tbl[i].lv, tbl[i].chg, tbl[i].al, tbl[i].pk);
        end

        // ack ignored in ALERT, accepted once back in WATCH
        step(1'b1, 1'b0, 8'd0, 1'b0);
        samples(4, 8'd50);
        samples(4, 8'd200);
        chk_all("ackA.enter", 2, 1, 1, 100);
        step(1'b0, 1'b0, 8'd0, 1'b1);
        chk_all("ackA.in_alert", 2, 0, 1, 100);
        samples(4, 8'd60);
        chk_all("ackA.to_watch", 1, 1, 1, 100);
        step(1'b0, 1'b1, 8'd60, 1'b1);
        chk_all("ackA.accepted", 1, 0, 0, 60);

        // idle cycles neither count nor break a streak
        step(1'b1, 1'b0, 8'd0, 1'b0);
        samples(1, 8'd50);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'd90, 1'b0);
        samples(2, 8'd50);
        chk_all("gap.third", 0, 0, 0, 50);
        samples(1, 8'd50);
        chk_all("gap.fourth", 1, 1, 0, 50);
        step(1'b0, 1'b0, 8'd0, 1'b0);
        chk_all("gap.pulse_end", 1, 0, 0, 50);

        // reset during a partial down-streak in ALERT
        step(1'b1, 1'b0, 8'd0, 1'b0);
        samples(4, 8'd50);
        samples(4, 8'd80);
        samples(2, 8'd50);
        chk_all("rstmid.partial", 2, 0, 1, 80);
        step(1'b1, 1'b1, 8'd50, 1'b1);
        chk_all("rstmid.reset", 0, 0, 0, 0);
        samples(3, 8'd50);
        chk_all("rstmid.after", 0, 0, 0, 50);

        // randomized traffic against the reference model
        begin
            int base;
            int k;
            base = 50;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 7) == 0) base = int'($urandom_range(0, 140));
                k = base + int'($urandom_range(0, 12)) - 6;
                if (k < 0) k = 0;
                if (k > 255) k = 255;
                step($urandom_range(0, 599) == 0,
                     $urandom_range(0, 9) < 8,
                     8'(k),
                     $urandom_range(0, 24) == 0);
                chk_all($sformatf("rand%0d", i), m_level, m_chg, m_alarm, m_peak);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
